scr1_axil_mem_arbiter: RTL and testbench
========================================

Name: scr1_axil_mem_arbiter

Overview:
- Parametrised N-master to 1-slave AXI4-Lite arbiter that merges the SCR1 core's instruction and data buses, plus optional extra masters such as a DMA engine, onto one shared memory/peripheral port.
- Read and write paths are arbitrated independently, so one read and one write can be in flight at once.
- Each path allows one outstanding transaction.
- Arbitration is selectable: fixed-priority or round-robin.

Parameters:
- NUM_M, 2, number of masters (2..8); master 0 is imem, master 1 is dmem.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- m_ar_addr  in  NUM_M*ADDR_W  per-master read address, packed with master i at slice i.
- m_ar_valid  in  NUM_M  read address valid.
- m_ar_ready  out  NUM_M  read address ready.
- m_r_data  out  DATA_W  read data, shared by all masters; qualified per master by m_r_valid.
- m_r_resp  out  2  read response, shared.
- m_r_valid  out  NUM_M  read data valid.
- m_r_ready  in  NUM_M  read data ready.
- m_aw_addr  in  NUM_M*ADDR_W  write address.
- m_aw_valid  in  NUM_M  write address valid.
- m_aw_ready  out  NUM_M  write address ready.
- m_w_data  in  NUM_M*DATA_W  write data.
- m_w_strb  in  NUM_M*DATA_W/8  write strobes.
- m_w_valid  in  NUM_M  write data valid.
- m_w_ready  out  NUM_M  write data ready.
- m_b_resp  out  2  write response, shared.
- m_b_valid  out  NUM_M  write response valid.
- m_b_ready  in  NUM_M  write response ready.
- s_ar_addr, s_ar_valid, s_ar_ready, s_r_data, s_r_resp, s_r_valid, s_r_ready: slave-side read channels; out/in mirrored, widths as above.
- s_aw_addr, s_aw_valid, s_aw_ready, s_w_data, s_w_strb, s_w_valid, s_w_ready, s_b_resp, s_b_valid, s_b_ready: slave-side write channels; out/in mirrored.

Behaviour:
- Reset (async assert, sync release):
  - Both FSMs go to IDLE.
  - Grants are cleared.
  - Round-robin pointers are set to 0, so master 0 has highest priority first.
  - All valid/ready outputs are 0; address/data/resp outputs are 0.
- Read FSM, states IDLE, AR, R:
  - IDLE: if any m_ar_valid, select a winner, register its index and address, and go to AR. Outputs during this cycle are 0.
  - AR: s_ar_valid=1 with the registered address. When s_ar_ready=1, pulse m_ar_ready[grant]=1 for that cycle and go to R.
  - The master AR handshake therefore completes in the same cycle as the slave AR handshake. Minimum latency from m_ar_valid to m_ar_ready is 2 cycles.
  - R: s_r_ready = m_r_ready[grant]; m_r_valid[grant] = s_r_valid; m_r_data/m_r_resp pass through combinationally.
  - On the r handshake, go to IDLE and, in mode 1, advance the pointer to grant+1 mod NUM_M.
- Write FSM, states IDLE, AW_W, B:
  - IDLE: arbitrate on m_aw_valid only and register the winner.
  - AW_W: AW and W are forwarded independently from the granted master. s_aw_valid is held until s_aw_ready; s_w_valid = m_w_valid[grant]; m_w_ready[grant] = s_w_ready.
  - AW_W tracks aw_done and w_done flags and goes to B when both are set. AW and W may complete in either order or in the same cycle.
  - W data presented by a master before it is granted is not accepted (m_w_ready=0).
  - B: b is passed through to the granted master as for R. On the b handshake, go to IDLE and advance the pointer as for reads.
- Arbitration:
  - Mode 0: the lowest set index wins.
  - Mode 1: the first set index at or after the pointer wins, wrapping around.
  - The grant is locked from IDLE exit until return to IDLE, and is never changed mid-transaction.
  - Non-granted masters see ready=0 and valid=0.
- Simultaneous events: a read and a write from the same or different masters proceed concurrently with no ordering between the channels.
- The slave is assumed to return exactly one response per request; responses (including SLVERR/DECERR) are forwarded unmodified.
- Reset mid-transaction aborts the transaction immediately. No response is generated for it.
- Width rules: index width is clog2(NUM_M), with a minimum of 1. The pointer wrap uses a compare against NUM_M-1, not a power-of-2 mask.

Test Plan:
- Single read, m0 ar_addr=0x100, slave ar_ready=1, r_data=0xDEADBEEF one cycle later: m_ar_ready[0] pulses at cycle 2; m_r_valid[0]=1 with data 0xDEADBEEF; m_r_valid[1] stays 0.
- ARB_MODE=0, m0 and m1 both request reads every cycle for 4 transactions: all 4 grants go to m0; m1 is starved.
- ARB_MODE=1 with the same stimulus: grant order is m0, m1, m0, m1; slave addresses alternate accordingly.
- Concurrent traffic: m1 writes addr 0x200, data 0x12345678, strb 0xF while m0 reads 0x300: both complete; s_w_data=0x12345678 and s_w_strb=0xF appear while the read is in R state.
- Write with m_w_valid asserted 3 cycles before m_aw_valid and s_aw_ready delayed 2 cycles: exactly one s_aw handshake and one s_w handshake occur; m_b_valid[grant] follows s_b_valid, with bresp=2'b10 forwarded unchanged.
- rst_n deasserted in R state with s_r_valid=0: all outputs are 0 asynchronously; after release, a fresh m1 read is granted in mode 1 (pointer reset to 0, m0 idle).

Source files
------------

// File: rtl/scr1_axil_mem_arbiter.sv
// rtl/scr1_axil_mem_arbiter.sv - N-master to 1-slave AXI4-Lite arbiter for the SCR1 memory port
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   m_ar_* / m_r_*        per-master read address and read data channels (packed, master i at slice i)
//   m_aw_* / m_w_* / m_b_* per-master write address, write data and write response channels
//   s_ar_* / s_r_*        shared slave-side read channels
//   s_aw_* / s_w_* / s_b_* shared slave-side write channels
module scr1_axil_mem_arbiter #(
  parameter int NUM_M    = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_M*ADDR_W-1:0]   m_ar_addr,
  input  logic [NUM_M-1:0]          m_ar_valid,
  output logic [NUM_M-1:0]          m_ar_ready,
  output logic [DATA_W-1:0]         m_r_data,
  output logic [1:0]                m_r_resp,
  output logic [NUM_M-1:0]          m_r_valid,
  input  logic [NUM_M-1:0]          m_r_ready,
  input  logic [NUM_M*ADDR_W-1:0]   m_aw_addr,
  input  logic [NUM_M-1:0]          m_aw_valid,
  output logic [NUM_M-1:0]          m_aw_ready,
  input  logic [NUM_M*DATA_W-1:0]   m_w_data,
  input  logic [NUM_M*DATA_W/8-1:0] m_w_strb,
  input  logic [NUM_M-1:0]          m_w_valid,
  output logic [NUM_M-1:0]          m_w_ready,
  output logic [1:0]                m_b_resp,
  output logic [NUM_M-1:0]          m_b_valid,
  input  logic [NUM_M-1:0]          m_b_ready,
  output logic [ADDR_W-1:0]         s_ar_addr,
  output logic                      s_ar_valid,
  input  logic                      s_ar_ready,
  input  logic [DATA_W-1:0]         s_r_data,
  input  logic [1:0]                s_r_resp,
  input  logic                      s_r_valid,
  output logic                      s_r_ready,
  output logic [ADDR_W-1:0]         s_aw_addr,
  output logic                      s_aw_valid,
  input  logic                      s_aw_ready,
  output logic [DATA_W-1:0]         s_w_data,
  output logic [DATA_W/8-1:0]       s_w_strb,
  output logic                      s_w_valid,
  input  logic                      s_w_ready,
  input  logic [1:0]                s_b_resp,
  input  logic                      s_b_valid,
  output logic                      s_b_ready
);

  localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW_W, WR_B} wr_state_t;

  // Wrap by compare so non-power-of-2 master counts cycle correctly.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_M - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Fixed priority scans from 0; round-robin scans from the pointer, wrapping.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_M-1:0] req,
                                            input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] res;
    logic             found;
    res   = '0;
    found = 1'b0;
    idx   = (ARB_MODE == 1) ? ptr : '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    return res;
  endfunction

  // ---------------- read path ----------------
  rd_state_t         rd_state, rd_state_nxt;
  logic [IDX_W-1:0]  rd_grant, rd_ptr, rd_win;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_win = pick(m_ar_valid, rd_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_grant <= '0;
      rd_ptr   <= '0;
      rd_addr  <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (rd_state == RD_IDLE && |m_ar_valid) begin
        rd_grant <= rd_win;
        rd_addr  <= m_ar_addr[rd_win*ADDR_W +: ADDR_W];
      end
      if (ARB_MODE == 1 && rd_state == RD_R && s_r_valid && s_r_ready)
        rd_ptr <= next_idx(rd_grant);
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    m_ar_ready   = '0;
    m_r_valid    = '0;
    m_r_data     = '0;
    m_r_resp     = '0;
    s_ar_valid   = 1'b0;
    s_ar_addr    = '0;
    s_r_ready    = 1'b0;
    case (rd_state)
      RD_IDLE: if (|m_ar_valid) rd_state_nxt = RD_AR;
      RD_AR: begin
        s_ar_valid = 1'b1;
        s_ar_addr  = rd_addr;
        // Master handshake completes together with the slave handshake.
        if (s_ar_ready) begin
          m_ar_ready[rd_grant] = 1'b1;
          rd_state_nxt         = RD_R;
        end
      end
      RD_R: begin
        s_r_ready           = m_r_ready[rd_grant];
        m_r_valid[rd_grant] = s_r_valid;
        m_r_data            = s_r_data;
        m_r_resp            = s_r_resp;
        if (s_r_valid && m_r_ready[rd_grant]) rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // ---------------- write path ----------------
  wr_state_t         wr_state, wr_state_nxt;
  logic [IDX_W-1:0]  wr_grant, wr_ptr, wr_win;
  logic [ADDR_W-1:0] wr_addr;
  logic              aw_done, w_done, aw_fin, w_fin;

  assign wr_win = pick(m_aw_valid, wr_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      wr_grant <= '0;
      wr_ptr   <= '0;
      wr_addr  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      if (wr_state == WR_IDLE && |m_aw_valid) begin
        wr_grant <= wr_win;
        wr_addr  <= m_aw_addr[wr_win*ADDR_W +: ADDR_W];
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end
      if (wr_state == WR_AW_W) begin
        aw_done <= aw_fin;
        w_done  <= w_fin;
      end
      if (ARB_MODE == 1 && wr_state == WR_B && s_b_valid && s_b_ready)
        wr_ptr <= next_idx(wr_grant);
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    m_aw_ready   = '0;
    m_w_ready    = '0;
    m_b_valid    = '0;
    m_b_resp     = '0;
    s_aw_valid   = 1'b0;
    s_aw_addr    = '0;
    s_w_valid    = 1'b0;
    s_w_data     = '0;
    s_w_strb     = '0;
    s_b_ready    = 1'b0;
    aw_fin       = aw_done;
    w_fin        = w_done;
    case (wr_state)
      WR_IDLE: if (|m_aw_valid) wr_state_nxt = WR_AW_W;
      WR_AW_W: begin
        // AW and W complete independently; each side is masked once done.
        s_aw_valid           = !aw_done;
        s_aw_addr            = wr_addr;
        m_aw_ready[wr_grant] = !aw_done && s_aw_ready;
        s_w_valid            = !w_done && m_w_valid[wr_grant];
        s_w_data             = m_w_data[wr_grant*DATA_W +: DATA_W];
        s_w_strb             = m_w_strb[wr_grant*STRB_W +: STRB_W];
        m_w_ready[wr_grant]  = !w_done && s_w_ready;
        aw_fin               = aw_done || (s_aw_valid && s_aw_ready);
        w_fin                = w_done || (s_w_valid && s_w_ready);
        if (aw_fin && w_fin) wr_state_nxt = WR_B;
      end
      WR_B: begin
        s_b_ready           = m_b_ready[wr_grant];
        m_b_valid[wr_grant] = s_b_valid;
        m_b_resp            = s_b_resp;
        if (s_b_valid && m_b_ready[wr_grant]) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

endmodule

// File: tb/tb_scr1_axil_mem_arbiter.sv
// tb/tb_scr1_axil_mem_arbiter.sv - directed bench for scr1_axil_mem_arbiter (fixed-priority and round-robin instances)
module tb_scr1_axil_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] m_ar_addr, m_aw_addr, m_w_data;
  logic [7:0]  m_w_strb;
  logic [1:0]  m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready;
  logic        s_ar_ready, s_r_valid, s_aw_ready, s_w_ready, s_b_valid;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp, s_b_resp;

  logic [1:0]  fp_m_ar_ready, fp_m_r_valid, fp_m_aw_ready, fp_m_w_ready, fp_m_b_valid;
  logic [1:0]  fp_m_r_resp, fp_m_b_resp;
  logic [31:0] fp_m_r_data, fp_s_ar_addr, fp_s_aw_addr, fp_s_w_data;
  logic [3:0]  fp_s_w_strb;
  logic        fp_s_ar_valid, fp_s_r_ready, fp_s_aw_valid, fp_s_w_valid, fp_s_b_ready;

  logic [1:0]  rr_m_ar_ready, rr_m_r_valid, rr_m_aw_ready, rr_m_w_ready, rr_m_b_valid;
  logic [1:0]  rr_m_r_resp, rr_m_b_resp;
  logic [31:0] rr_m_r_data, rr_s_ar_addr, rr_s_aw_addr, rr_s_w_data;
  logic [3:0]  rr_s_w_strb;
  logic        rr_s_ar_valid, rr_s_r_ready, rr_s_aw_valid, rr_s_w_valid, rr_s_b_ready;

  scr1_axil_mem_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(fp_m_ar_ready),
    .m_r_data(fp_m_r_data), .m_r_resp(fp_m_r_resp), .m_r_valid(fp_m_r_valid), .m_r_ready(m_r_ready),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(fp_m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(fp_m_w_ready),
    .m_b_resp(fp_m_b_resp), .m_b_valid(fp_m_b_valid), .m_b_ready(m_b_ready),
    .s_ar_addr(fp_s_ar_addr), .s_ar_valid(fp_s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(fp_s_r_ready),
    .s_aw_addr(fp_s_aw_addr), .s_aw_valid(fp_s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(fp_s_w_data), .s_w_strb(fp_s_w_strb), .s_w_valid(fp_s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(fp_s_b_ready)
  );

  scr1_axil_mem_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(rr_m_ar_ready),
    .m_r_data(rr_m_r_data), .m_r_resp(rr_m_r_resp), .m_r_valid(rr_m_r_valid), .m_r_ready(m_r_ready),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(rr_m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(rr_m_w_ready),
    .m_b_resp(rr_m_b_resp), .m_b_valid(rr_m_b_valid), .m_b_ready(m_b_ready),
    .s_ar_addr(rr_s_ar_addr), .s_ar_valid(rr_s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(rr_s_r_ready),
    .s_aw_addr(rr_s_aw_addr), .s_aw_valid(rr_s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(rr_s_w_data), .s_w_strb(rr_s_w_strb), .s_w_valid(rr_s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(rr_s_b_ready)
  );

  wire fp_busy = |{fp_m_ar_ready, fp_m_r_valid, fp_m_aw_ready, fp_m_w_ready, fp_m_b_valid,
                   fp_m_r_resp, fp_m_b_resp, fp_m_r_data, fp_s_ar_addr, fp_s_aw_addr,
                   fp_s_w_data, fp_s_w_strb, fp_s_ar_valid, fp_s_r_ready, fp_s_aw_valid,
                   fp_s_w_valid, fp_s_b_ready};
  wire rr_busy = |{rr_m_ar_ready, rr_m_r_valid, rr_m_aw_ready, rr_m_w_ready, rr_m_b_valid,
                   rr_m_r_resp, rr_m_b_resp, rr_m_r_data, rr_s_ar_addr, rr_s_aw_addr,
                   rr_s_w_data, rr_s_w_strb, rr_s_ar_valid, rr_s_r_ready, rr_s_aw_valid,
                   rr_s_w_valid, rr_s_b_ready};

  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;
  always @(posedge clk) begin
    if (rr_s_aw_valid && s_aw_ready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (rr_s_w_valid && s_w_ready)   w_hs_cnt  <= w_hs_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_ar_addr = '0; m_aw_addr = '0; m_w_data = '0; m_w_strb = '0;
    m_ar_valid = '0; m_r_ready = '0; m_aw_valid = '0; m_w_valid = '0; m_b_ready = '0;
    s_ar_ready = 1'b0; s_r_valid = 1'b0; s_aw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0;
    s_r_data = '0; s_r_resp = '0; s_b_resp = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_fp_outputs", 64'(fp_busy), 64'd0);
    chk("rst_rr_outputs", 64'(rr_busy), 64'd0);
    #2;
    rst_n = 1'b1;
  endtask

  int          a0, w0;
  logic [1:0]  e_grant;
  logic [31:0] e_addr;

  initial begin
    // Single read from m0
    do_reset();
    tick();
    m_ar_valid = 2'b01; m_ar_addr[31:0] = 32'h100; s_ar_ready = 1'b1; m_r_ready = 2'b01;
    #2;
    chk("t1_idle_ar_ready", 64'(rr_m_ar_ready), 64'd0);
    chk("t1_idle_s_ar_valid", 64'(rr_s_ar_valid), 64'd0);
    tick(); #2;
    chk("t1_ar_ready", 64'(rr_m_ar_ready), 64'b01);
    chk("t1_s_ar_valid", 64'(rr_s_ar_valid), 64'd1);
    chk("t1_s_ar_addr", 64'(rr_s_ar_addr), 64'h100);
    chk("t1_fp_ar_ready", 64'(fp_m_ar_ready), 64'b01);
    tick();
    m_ar_valid = 2'b00; s_r_valid = 1'b1; s_r_data = 32'hDEADBEEF;
    #2;
    chk("t1_r_valid", 64'(rr_m_r_valid), 64'b01);
    chk("t1_r_data", 64'(rr_m_r_data), 64'hDEADBEEF);
    chk("t1_s_r_ready", 64'(rr_s_r_ready), 64'd1);
    chk("t1_fp_r_valid", 64'(fp_m_r_valid), 64'b01);
    tick();
    s_r_valid = 1'b0;
    #2;
    chk("t1_done_r_valid", 64'(rr_m_r_valid), 64'd0);
    chk("t1_done_busy", 64'(rr_busy), 64'd0);

    // Both masters requesting reads continuously
    do_reset();
    tick();
    m_ar_valid = 2'b11; m_ar_addr = {32'h2000, 32'h1000}; m_r_ready = 2'b11;
    s_ar_ready = 1'b1; s_r_valid = 1'b1; s_r_data = 32'h5A5A0000;
    for (int t = 0; t < 4; t++) begin
      e_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
      e_addr  = (t % 2 == 0) ? 32'h1000 : 32'h2000;
      tick(); #2;
      chk("t2_fp_grant", 64'(fp_m_ar_ready), 64'b01);
      chk("t2_fp_addr", 64'(fp_s_ar_addr), 64'h1000);
      chk("t3_rr_grant", 64'(rr_m_ar_ready), 64'(e_grant));
      chk("t3_rr_addr", 64'(rr_s_ar_addr), 64'(e_addr));
      tick(); #2;
      chk("t2_fp_r_valid", 64'(fp_m_r_valid), 64'b01);
      chk("t3_rr_r_valid", 64'(rr_m_r_valid), 64'(e_grant));
      tick();
    end

    // Concurrent m1 write and m0 read
    do_reset();
    tick();
    m_aw_valid = 2'b10; m_aw_addr[63:32] = 32'h200;
    m_w_valid = 2'b10; m_w_data[63:32] = 32'h12345678; m_w_strb[7:4] = 4'hF; m_b_ready = 2'b10;
    m_ar_valid = 2'b01; m_ar_addr[31:0] = 32'h300; m_r_ready = 2'b01; s_ar_ready = 1'b1;
    tick(); #2;
    chk("t4_s_ar_addr", 64'(rr_s_ar_addr), 64'h300);
    chk("t4_s_aw_addr", 64'(rr_s_aw_addr), 64'h200);
    chk("t4_s_aw_valid", 64'(rr_s_aw_valid), 64'd1);
    tick();
    m_ar_valid = 2'b00; s_aw_ready = 1'b1; s_w_ready = 1'b1;
    #2;
    chk("t4_read_in_r", 64'(rr_s_r_ready), 64'd1);
    chk("t4_s_w_data", 64'(rr_s_w_data), 64'h12345678);
    chk("t4_s_w_strb", 64'(rr_s_w_strb), 64'hF);
    chk("t4_s_w_valid", 64'(rr_s_w_valid), 64'd1);
    chk("t4_m_aw_ready", 64'(rr_m_aw_ready), 64'b10);
    chk("t4_m_w_ready", 64'(rr_m_w_ready), 64'b10);
    tick();
    m_aw_valid = 2'b00; m_w_valid = 2'b00; s_aw_ready = 1'b0; s_w_ready = 1'b0;
    s_b_valid = 1'b1; s_b_resp = 2'b00; s_r_valid = 1'b1; s_r_data = 32'hCAFE0001;
    #2;
    chk("t4_b_valid", 64'(rr_m_b_valid), 64'b10);
    chk("t4_r_valid", 64'(rr_m_r_valid), 64'b01);
    chk("t4_r_data", 64'(rr_m_r_data), 64'hCAFE0001);
    tick();
    s_b_valid = 1'b0; s_r_valid = 1'b0;
    #2;
    chk("t4_done_b_valid", 64'(rr_m_b_valid), 64'd0);
    chk("t4_done_r_valid", 64'(rr_m_r_valid), 64'd0);

    // Early W, delayed AW ready, SLVERR response
    do_reset();
    a0 = aw_hs_cnt; w0 = w_hs_cnt;
    tick();
    m_w_valid = 2'b01; m_w_data[31:0] = 32'hA5A5A5A5; m_w_strb[3:0] = 4'h3; s_w_ready = 1'b1;
    m_b_ready = 2'b01;
    #2;
    chk("t5_early_w_ready0", 64'(rr_m_w_ready), 64'd0);
    tick(); tick(); #2;
    chk("t5_early_w_ready2", 64'(rr_m_w_ready), 64'd0);
    chk("t5_early_s_w_valid", 64'(rr_s_w_valid), 64'd0);
    tick();
    m_aw_valid = 2'b01; m_aw_addr[31:0] = 32'h40;
    #2;
    chk("t5_idle_w_ready", 64'(rr_m_w_ready), 64'd0);
    tick(); #2;
    chk("t5_s_w_valid", 64'(rr_s_w_valid), 64'd1);
    chk("t5_m_w_ready", 64'(rr_m_w_ready), 64'b01);
    chk("t5_s_aw_valid", 64'(rr_s_aw_valid), 64'd1);
    chk("t5_s_w_strb", 64'(rr_s_w_strb), 64'h3);
    tick();
    m_w_valid = 2'b00;
    #2;
    chk("t5_w_done_s_w_valid", 64'(rr_s_w_valid), 64'd0);
    chk("t5_aw_held", 64'(rr_s_aw_valid), 64'd1);
    tick();
    s_aw_ready = 1'b1;
    #2;
    chk("t5_m_aw_ready", 64'(rr_m_aw_ready), 64'b01);
    tick();
    m_aw_valid = 2'b00; s_aw_ready = 1'b0;
    #2;
    chk("t5_b_wait", 64'(rr_m_b_valid), 64'd0);
    tick();
    s_b_valid = 1'b1; s_b_resp = 2'b10;
    #2;
    chk("t5_b_valid", 64'(rr_m_b_valid), 64'b01);
    chk("t5_b_resp", 64'(rr_m_b_resp), 64'b10);
    tick();
    s_b_valid = 1'b0;
    #2;
    chk("t5_aw_hs_count", 64'(aw_hs_cnt - a0), 64'd1);
    chk("t5_w_hs_count", 64'(w_hs_cnt - w0), 64'd1);
    chk("t5_done_b_valid", 64'(rr_m_b_valid), 64'd0);

    // Reset in R state, then fresh m1 read
    do_reset();
    tick();
    m_ar_valid = 2'b01; m_ar_addr[31:0] = 32'h500; s_ar_ready = 1'b1; m_r_ready = 2'b01;
    tick();
    tick();
    m_ar_valid = 2'b00;
    #2;
    chk("t6_in_r", 64'(rr_s_r_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_rr", 64'(rr_busy), 64'd0);
    chk("t6_async_fp", 64'(fp_busy), 64'd0);
    clear_inputs();
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    tick();
    m_ar_valid = 2'b10; m_ar_addr[63:32] = 32'h600; m_r_ready = 2'b10; s_ar_ready = 1'b1;
    tick(); #2;
    chk("t6_m1_ar_ready", 64'(rr_m_ar_ready), 64'b10);
    chk("t6_m1_ar_addr", 64'(rr_s_ar_addr), 64'h600);
    tick();
    m_ar_valid = 2'b00; s_r_valid = 1'b1; s_r_data = 32'h77;
    #2;
    chk("t6_m1_r_valid", 64'(rr_m_r_valid), 64'b10);
    chk("t6_m1_r_data", 64'(rr_m_r_data), 64'h77);
    tick();
    s_r_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
